// File: rtl/sync_fifo_mem.sv
// Register-array storage for sync_fifo: one synchronous write port and one
// synchronous read port. Only the read register is reset; the array is not.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and registered read port.
// Define SYNC_FIFO_LEVEL_EN to expose the current fill count on port level.
module sync_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        wr_en,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        full,
`ifdef SYNC_FIFO_LEVEL_EN
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
`else
  output logic                        empty
`endif
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STAGES = 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             wr_acc, rd_acc;
  logic [STAGES:0]  vld_pipe;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are registered from the next count so they are glitch-free outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  assign vld_pipe[0] = rd_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_pipe[STAGES:1] <= '0;
    else          vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign rd_valid = vld_pipe[STAGES];

`ifdef SYNC_FIFO_LEVEL_EN
  assign level = count;
`endif

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .AW        (PTR_W)
  ) u_mem (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=1, FIFO_DEPTH=8).
// Define SYNC_FIFO_LEVEL_EN to also exercise the level port.
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [0:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [0:0] rd_data;
  logic       rd_valid, full, empty;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [3:0] level;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(1), .FIFO_DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .full    (full),
`ifdef SYNC_FIFO_LEVEL_EN
    .empty   (empty),
    .level   (level)
`else
    .empty   (empty)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 1'b0) begin errors++; $display("FAIL reset_rd_data got=%b exp=0", rd_data); end
    reset_n = 1'b1;
    step();
  endtask

  // Fill with 1,0,1,0,...; the 9th write carries 0 and must be dropped.
  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
      checks++;
      if (full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 7)); end
      checks++;
      if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
    end
    wr_data = 1'b0;
    step();
    wr_en = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL overflow_full got=%b exp=1", full); end
  endtask

  task automatic test_drain();
    logic exp_d;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      step();
      exp_d = (i % 2 == 0) ? 1'b1 : 1'b0;
      checks++;
      if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, rd_valid); end
      checks++;
      if (rd_data !== exp_d) begin errors++; $display("FAIL drain_data[%0d] got=%b exp=%b", i, rd_data, exp_d); end
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL drain_full[%0d] got=%b exp=0", i, full); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    step();
    rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL underflow_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 1'b0) begin errors++; $display("FAIL underflow_hold got=%b exp=0", rd_data); end
  endtask

  task automatic test_read_empty();
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL rdempty_valid[%0d] got=%b exp=0", i, rd_valid); end
    end
    // Write and read on the same edge while empty: no bypass.
    wr_en = 1'b1; wr_data = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL nobypass_valid got=%b exp=0", rd_valid); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL nobypass_empty got=%b exp=0", empty); end
    step();
    rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rdempty_after_valid got=%b exp=1", rd_valid); end
    checks++; if (rd_data !== 1'b1) begin errors++; $display("FAIL rdempty_after_data got=%b exp=1", rd_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rdempty_after_empty got=%b exp=1", empty); end
  endtask

  // Prime 4 words, then stream 12 with read+write each edge; pointers wrap.
  task automatic test_back_to_back();
    logic [15:0] pat;
    pat = 16'b1010_0110_0011_1001;
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; wr_data = pat[k];
      step();
    end
    rd_en = 1'b1;
    for (int j = 0; j < 12; j++) begin
      wr_data = pat[j+4];
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== pat[j]) begin
        errors++; $display("FAIL b2b_data[%0d] got=%b/%b exp=1/%b", j, rd_valid, rd_data, pat[j]);
      end
      checks++;
      if (full !== 1'b0 || empty !== 1'b0) begin
        errors++; $display("FAIL b2b_flags[%0d] got=%b%b exp=00", j, full, empty);
      end
`ifdef SYNC_FIFO_LEVEL_EN
      checks++;
      if (level !== 4'd4) begin errors++; $display("FAIL b2b_level[%0d] got=%0d exp=4", j, level); end
`endif
    end
    wr_en = 1'b0;
    for (int j = 12; j < 16; j++) begin
      step();
      checks++;
      if (rd_data !== pat[j]) begin errors++; $display("FAIL b2b_tail[%0d] got=%b exp=%b", j, rd_data, pat[j]); end
    end
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  // Reset with 2 words queued and rd_data=1: all state clears immediately.
  task automatic test_reset_mid();
    wr_en = 1'b1; wr_data = 1'b1;
    step(); step(); step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midrst_full got=%b exp=0", full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 1'b0) begin errors++; $display("FAIL midrst_data got=%b exp=0", rd_data); end
    step();
    reset_n = 1'b1;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL postrst_valid got=%b exp=0", rd_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL postrst_empty got=%b exp=1", empty); end
  endtask

`ifdef SYNC_FIFO_LEVEL_EN
  task automatic test_level();
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL level_start got=%0d exp=0", level); end
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 1'b0;
      step();
      checks++;
      if (level !== 4'(i)) begin errors++; $display("FAIL level_fill[%0d] got=%0d exp=%0d", i, level, i); end
    end
    wr_en = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      rd_en = 1'b1;
      step();
      checks++;
      if (level !== 4'(i)) begin errors++; $display("FAIL level_drain[%0d] got=%0d exp=%0d", i, level, i); end
    end
    rd_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_read_empty();
    test_back_to_back();
    test_reset_mid();
`ifdef SYNC_FIFO_LEVEL_EN
    test_level();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
